// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter: EX results vs. non-stallable LSU loads, with parked-load FIFO.
// Optional macro IBEX_RF_WR_ARB_FWD_EN adds forwarding of parked load data to ID.
module ibex_rf_wr_arbiter #(
   parameter int unsigned BufDepth   = 2,
   parameter int unsigned MaxExStall = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      ex_valid_i,
   output logic                      ex_ready_o,
   input  logic [4:0]                ex_waddr_i,
   input  logic [31:0]               ex_wdata_i,
   input  logic                      lsu_valid_i,
   input  logic [4:0]                lsu_waddr_i,
   input  logic [31:0]               lsu_wdata_i,
   output logic                      rf_we_o,
   output logic [4:0]                rf_waddr_o,
   output logic [31:0]               rf_wdata_o,
   input  logic [4:0]                raddr_a_i,
   input  logic [4:0]                raddr_b_i,
   output logic                      hazard_a_o,
   output logic                      hazard_b_o,
   output logic [$clog2(BufDepth):0] buf_count_o
`ifdef IBEX_RF_WR_ARB_FWD_EN
   ,
   output logic                      fwd_hit_a_o,
   output logic                      fwd_hit_b_o,
   output logic [31:0]               fwd_data_a_o,
   output logic [31:0]               fwd_data_b_o
`endif
);

   localparam int unsigned PtrW = $clog2(BufDepth);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] r_rd_ptr;
   logic [PtrW-1:0] r_wr_ptr;
   logic [CntW-1:0] r_count;
   logic [3:0]      r_stall_cnt;
   logic [4:0]      r_buf_addr [BufDepth];
   logic [31:0]     r_buf_data [BufDepth];

   logic            w_ex_req;
   logic            w_lsu_req;
   logic            w_empty;
   logic            w_full;
   logic            w_starve;
   logic            w_grant_buf;
   logic            w_grant_lsu;
   logic            w_grant_ex;
   logic            w_push;
   logic            w_pop;
   logic [PtrW-1:0] w_idx;
   logic            w_hit_a;
   logic            w_hit_b;
`ifdef IBEX_RF_WR_ARB_FWD_EN
   logic [31:0]     w_fwd_a;
   logic [31:0]     w_fwd_b;
`endif

   // x0 writes never occupy the port
   assign w_ex_req  = ex_valid_i  && (ex_waddr_i  != 5'd0);
   assign w_lsu_req = lsu_valid_i && (lsu_waddr_i != 5'd0);
   assign w_empty   = (r_count == CntW'(0));
   assign w_full    = (r_count == CntW'(BufDepth));
   assign w_starve  = w_ex_req && (r_stall_cnt == 4'(MaxExStall)) && !w_full;

   always_comb begin
      w_grant_buf = 1'b0;
      w_grant_lsu = 1'b0;
      w_grant_ex  = 1'b0;
      if (!rst_i) begin
         if (w_starve)       w_grant_ex  = 1'b1;
         else if (!w_empty)  w_grant_buf = 1'b1;
         else if (w_lsu_req) w_grant_lsu = 1'b1;
         else if (w_ex_req)  w_grant_ex  = 1'b1;
      end
   end

   assign w_pop      = w_grant_buf;
   assign w_push     = w_lsu_req && !w_grant_lsu && !rst_i;
   assign ex_ready_o = w_grant_ex || (!rst_i && ex_valid_i && (ex_waddr_i == 5'd0));

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = 5'd0;
      rf_wdata_o = 32'd0;
      if (w_grant_buf) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = r_buf_addr[r_rd_ptr];
         rf_wdata_o = r_buf_data[r_rd_ptr];
      end else if (w_grant_lsu) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = lsu_waddr_i;
         rf_wdata_o = lsu_wdata_i;
      end else if (w_grant_ex) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = ex_waddr_i;
         rf_wdata_o = ex_wdata_i;
      end
   end

   // Walk oldest to youngest so the last match is the youngest entry
   always_comb begin
      w_idx   = r_rd_ptr;
      w_hit_a = 1'b0;
      w_hit_b = 1'b0;
`ifdef IBEX_RF_WR_ARB_FWD_EN
      w_fwd_a = 32'd0;
      w_fwd_b = 32'd0;
`endif
      for (int unsigned k = 0; k < BufDepth; k++) begin
         w_idx = r_rd_ptr + PtrW'(k);
         if (CntW'(k) < r_count) begin
            if ((raddr_a_i != 5'd0) && (r_buf_addr[w_idx] == raddr_a_i)) begin
               w_hit_a = 1'b1;
`ifdef IBEX_RF_WR_ARB_FWD_EN
               w_fwd_a = r_buf_data[w_idx];
`endif
            end
            if ((raddr_b_i != 5'd0) && (r_buf_addr[w_idx] == raddr_b_i)) begin
               w_hit_b = 1'b1;
`ifdef IBEX_RF_WR_ARB_FWD_EN
               w_fwd_b = r_buf_data[w_idx];
`endif
            end
         end
      end
   end

`ifdef IBEX_RF_WR_ARB_FWD_EN
   assign hazard_a_o   = 1'b0;
   assign hazard_b_o   = 1'b0;
   assign fwd_hit_a_o  = w_hit_a;
   assign fwd_hit_b_o  = w_hit_b;
   assign fwd_data_a_o = w_fwd_a;
   assign fwd_data_b_o = w_fwd_b;
`else
   assign hazard_a_o = w_hit_a;
   assign hazard_b_o = w_hit_b;
`endif

   assign buf_count_o = r_count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_stall_cnt <= '0;
         for (int i = 0; i < BufDepth; i++) begin
            r_buf_addr[i] <= '0;
            r_buf_data[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_buf_addr[r_wr_ptr] <= lsu_waddr_i;
            r_buf_data[r_wr_ptr] <= lsu_wdata_i;
            r_wr_ptr             <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
         r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
         if (ex_valid_i && !ex_ready_o) begin
            if (r_stall_cnt != 4'(MaxExStall)) r_stall_cnt <= r_stall_cnt + 4'd1;
         end else begin
            r_stall_cnt <= '0;
         end
      end
   end

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Directed bench for ibex_rf_wr_arbiter with a scoreboard of expected RF writes.
// Build with IBEX_RF_WR_ARB_FWD_EN defined to exercise the forwarding ports.
module tb_ibex_rf_wr_arbiter;

`ifdef IBEX_RF_WR_ARB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic        lsu_valid;
   logic [4:0]  lsu_waddr;
   logic [31:0] lsu_wdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  raddr_a;
   logic [4:0]  raddr_b;
   logic        hazard_a;
   logic        hazard_b;
   logic [1:0]  buf_count;
`ifdef IBEX_RF_WR_ARB_FWD_EN
   logic        fwd_hit_a;
   logic        fwd_hit_b;
   logic [31:0] fwd_data_a;
   logic [31:0] fwd_data_b;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   ibex_rf_wr_arbiter #(.BufDepth(2), .MaxExStall(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .ex_valid_i  (ex_valid),
      .ex_ready_o  (ex_ready),
      .ex_waddr_i  (ex_waddr),
      .ex_wdata_i  (ex_wdata),
      .lsu_valid_i (lsu_valid),
      .lsu_waddr_i (lsu_waddr),
      .lsu_wdata_i (lsu_wdata),
      .rf_we_o     (rf_we),
      .rf_waddr_o  (rf_waddr),
      .rf_wdata_o  (rf_wdata),
      .raddr_a_i   (raddr_a),
      .raddr_b_i   (raddr_b),
      .hazard_a_o  (hazard_a),
      .hazard_b_o  (hazard_b),
      .buf_count_o (buf_count)
`ifdef IBEX_RF_WR_ARB_FWD_EN
      ,
      .fwd_hit_a_o  (fwd_hit_a),
      .fwd_hit_b_o  (fwd_hit_b),
      .fwd_data_a_o (fwd_data_a),
      .fwd_data_b_o (fwd_data_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Compare the current RF write (or idle state) against the scoreboard head
   task automatic check_write();
      wr_t e;
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", 32'(rf_waddr), 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(rf_waddr), 32'(e.a));
            chk("wr_data", rf_wdata, e.d);
         end
      end else begin
         chk("idle_we", 32'(rf_we), 32'h0);
         chk("idle_addr", 32'(rf_waddr), 32'h0);
         chk("idle_data", rf_wdata, 32'h0);
      end
   endtask

   task automatic tick();
      #1 check_write();
      @(negedge clk);
   endtask

   function automatic logic [4:0] la(input int run, input int c);
      return (run == 1 && c >= 8) ? 5'd7 : 5'(10 + c);
   endfunction

   function automatic logic [31:0] ld(input int run, input int c);
      return 32'h100 * 32'(run + 1) + 32'(c);
   endfunction

   // EX held while LSU streams: 4 direct loads, EX by starvation, then a second starvation fills the buffer
   task automatic run_stream(input int run);
      for (int c = 0; c < 10; c++) begin
         lsu_valid = 1'b1;
         lsu_waddr = la(run, c);
         lsu_wdata = ld(run, c);
         ex_valid  = 1'b1;
         ex_waddr  = (c < 5) ? 5'd9 : 5'd20;
         ex_wdata  = (c < 5) ? 32'h900 + 32'(run) : 32'hA00 + 32'(run);
         raddr_a   = (run == 0) ? 5'd19 : 5'd7;
         raddr_b   = 5'd0;
         if (c < 4)       push(la(run, c), ld(run, c));
         else if (c == 4) push(5'd9, 32'h900 + 32'(run));
         else if (c < 9)  push(la(run, c - 1), ld(run, c - 1));
         else             push(5'd20, 32'hA00 + 32'(run));
         #1 chk($sformatf("stream%0d_ex_ready_c%0d", run, c), 32'(ex_ready), (c == 4 || c == 9) ? 32'h1 : 32'h0);
         if (run == 0 && c == 9) chk("enqueue_not_yet_visible", 32'(hazard_a), 32'h0);
         tick();
         chk($sformatf("stream%0d_count_c%0d", run, c), 32'(buf_count), (c < 4) ? 32'h0 : (c < 9) ? 32'h1 : 32'h2);
      end
      lsu_valid = 1'b0;
      ex_valid  = 1'b0;
   endtask

   initial begin
      clk = 1'b0; rst = 1'b0;
      ex_valid = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0;
      lsu_valid = 1'b0; lsu_waddr = 5'd0; lsu_wdata = 32'd0;
      raddr_a = 5'd0; raddr_b = 5'd0;
      #1 rst = 1'b1;
      // Requests during reset must not reach the port
      ex_valid = 1'b1; ex_waddr = 5'd5; lsu_valid = 1'b1; lsu_waddr = 5'd6;
      #1;
      chk("reset_we", 32'(rf_we), 32'h0);
      chk("reset_ex_ready", 32'(ex_ready), 32'h0);
      chk("reset_count", 32'(buf_count), 32'h0);
      chk("reset_hazard_a", 32'(hazard_a), 32'h0);
      ex_valid = 1'b0; lsu_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // EX only
      ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h11;
      push(5'd5, 32'h11);
      #1 chk("ex_only_ready", 32'(ex_ready), 32'h1);
      tick();
      ex_valid = 1'b0;

      // Collision with empty buffer: LSU direct first, EX next cycle
      ex_valid = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h33;
      lsu_valid = 1'b1; lsu_waddr = 5'd4; lsu_wdata = 32'hAA;
      push(5'd4, 32'hAA);
      push(5'd3, 32'h33);
      #1 chk("collide_ex_ready_c0", 32'(ex_ready), 32'h0);
      tick();
      lsu_valid = 1'b0;
      #1 chk("collide_ex_ready_c1", 32'(ex_ready), 32'h1);
      tick();
      ex_valid = 1'b0;
      chk("collide_count", 32'(buf_count), 32'h0);

      // x0 writes
      ex_valid = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'h55;
      #1 chk("x0_ex_ready", 32'(ex_ready), 32'h1);
      chk("x0_ex_we", 32'(rf_we), 32'h0);
      tick();
      ex_valid = 1'b0;
      lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'h66;
      #1 chk("x0_lsu_we", 32'(rf_we), 32'h0);
      tick();
      lsu_valid = 1'b0;
      chk("x0_lsu_count", 32'(buf_count), 32'h0);

      // Starvation, fill and in-order drain with hazards
      run_stream(0);
      push(5'd18, ld(0, 8));
      push(5'd19, ld(0, 9));
      raddr_a = 5'd19; raddr_b = 5'd18;
      #1;
      chk("drain_hazard_a_c0", 32'(hazard_a), FWD ? 32'h0 : 32'h1);
      chk("drain_hazard_b_c0", 32'(hazard_b), FWD ? 32'h0 : 32'h1);
`ifdef IBEX_RF_WR_ARB_FWD_EN
      chk("drain_fwd_a", fwd_data_a, ld(0, 9));
      chk("drain_fwd_hit_b", 32'(fwd_hit_b), 32'h1);
`endif
      tick();
      chk("drain_count_c0", 32'(buf_count), 32'h1);
      chk("drain_hazard_a_c1", 32'(hazard_a), FWD ? 32'h0 : 32'h1);
      chk("drain_hazard_b_c1", 32'(hazard_b), 32'h0);
      tick();
      chk("drain_count_c1", 32'(buf_count), 32'h0);
      chk("drain_hazard_a_c2", 32'(hazard_a), 32'h0);
      raddr_b = 5'd0;

      // Two parked r7 writes, then reset mid-drain
      run_stream(1);
      raddr_a = 5'd7;
      #1;
      chk("r7_hazard_a", 32'(hazard_a), FWD ? 32'h0 : 32'h1);
`ifdef IBEX_RF_WR_ARB_FWD_EN
      chk("r7_fwd_hit_a", 32'(fwd_hit_a), 32'h1);
      chk("r7_fwd_data_a", fwd_data_a, 32'h209);
`endif
      ex_valid = 1'b1; ex_waddr = 5'd8; lsu_valid = 1'b1; lsu_waddr = 5'd9;
      rst = 1'b1;
      #1;
      chk("midrst_count", 32'(buf_count), 32'h0);
      chk("midrst_we", 32'(rf_we), 32'h0);
      chk("midrst_hazard_a", 32'(hazard_a), 32'h0);
      chk("midrst_hazard_b", 32'(hazard_b), 32'h0);
      exp_q.delete();
      ex_valid = 1'b0; lsu_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_count", 32'(buf_count), 32'h0);

      chk("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
